// File: rtl/demod_frame_sched_if.sv
// Sample stream into the frame scheduler and data-carrier stream out to the demodulator.
interface demod_frame_sched_if;
  logic [31:0] DAT_I;
  logic        CYC_I, STB_I, WE_I, ACK_O;
  logic [31:0] DAT_O;
  logic        CYC_O, STB_O, WE_O, ACK_I;

  modport master (output DAT_I, CYC_I, STB_I, WE_I, ACK_I,
                  input  ACK_O, DAT_O, CYC_O, STB_O, WE_O);
  modport slave  (input  DAT_I, CYC_I, STB_I, WE_I, ACK_I,
                  output ACK_O, DAT_O, CYC_O, STB_O, WE_O);
endinterface

// File: rtl/demod_frame_sched.sv
// OFDM frame scheduler: strips and decodes the header symbol, forwards data carriers,
// diverts pilots to a capture port and counts data symbols until the frame completes.
module demod_frame_sched #(
  parameter int          NCAR    = 52,
  parameter int          NSYM    = 10,
  parameter int          HDR_IDX = 6,
  parameter int          PIL0    = 6,
  parameter int          PIL1    = 20,
  parameter int          PIL2    = 31,
  parameter int          PIL3    = 45,
  parameter logic [15:0] QAM_TH  = 16'd1024,
  parameter logic [15:0] QPSK_TH = 16'd128
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  demod_frame_sched_if.slave   bus,
  output logic                 QAM,
  output logic                 QPSK,
  output logic [31:0]          PIL_DAT,
  output logic [1:0]           PIL_IDX,
  output logic                 PIL_VAL,
  output logic [7:0]           SYM_CNT,
  output logic                 MODE_ERR,
  output logic                 FRM_DONE
);
  localparam int CW = (NCAR > 1) ? $clog2(NCAR) : 1;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_DONE, S_DROP} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  car_q, car_d;
  logic [7:0]     sym_q, sym_d;
  logic [15:0]    hdr_re_q, hdr_re_d;
  logic           qam_q, qam_d, qpsk_q, qpsk_d;
  logic [31:0]    dat_o_q, dat_o_d;
  logic           stb_o_q, stb_o_d, cyc_o_q, cyc_o_d;
  logic [31:0]    pil_dat_q, pil_dat_d;
  logic [1:0]     pil_idx_q, pil_idx_d;
  logic           pil_val_q, pil_val_d;
  logic           mode_err_q, mode_err_d, frm_done_q, frm_done_d;

  logic        ena, out_halt, acc, car_last, is_hdr_car, pil_hit;
  logic [1:0]  pil_k;
  logic [15:0] hdr_re;

  assign ena        = bus.CYC_I & bus.STB_I & bus.WE_I;
  assign out_halt   = stb_o_q & ~bus.ACK_I;
  assign acc        = ena & ~out_halt;
  assign car_last   = (car_q == CW'(NCAR - 1));
  assign is_hdr_car = (car_q == CW'(HDR_IDX));
  // Bypass lets the decode work even when the mode carrier is the last header carrier.
  assign hdr_re     = is_hdr_car ? bus.DAT_I[15:0] : hdr_re_q;

  always_comb begin
    pil_hit = 1'b1;
    pil_k   = 2'd0;
    if      (car_q == CW'(PIL0)) pil_k = 2'd0;
    else if (car_q == CW'(PIL1)) pil_k = 2'd1;
    else if (car_q == CW'(PIL2)) pil_k = 2'd2;
    else if (car_q == CW'(PIL3)) pil_k = 2'd3;
    else                         pil_hit = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    car_d      = car_q;
    sym_d      = sym_q;
    hdr_re_d   = hdr_re_q;
    qam_d      = qam_q;
    qpsk_d     = qpsk_q;
    dat_o_d    = dat_o_q;
    stb_o_d    = out_halt ? stb_o_q : 1'b0;
    cyc_o_d    = (~bus.CYC_I & ~stb_o_q) ? 1'b0 : cyc_o_q;
    pil_dat_d  = pil_dat_q;
    pil_idx_d  = pil_idx_q;
    pil_val_d  = 1'b0;
    mode_err_d = 1'b0;
    frm_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (acc) begin
          state_d = S_HDR;
          car_d   = CW'(1);
          if (is_hdr_car) hdr_re_d = bus.DAT_I[15:0];
        end
      end
      S_HDR: begin
        if (acc) begin
          if (is_hdr_car) hdr_re_d = bus.DAT_I[15:0];
          if (car_last) begin
            car_d = '0;
            if (!hdr_re[15] && hdr_re >= QAM_TH) begin
              qam_d   = 1'b1;
              state_d = S_DATA;
            end else if (!hdr_re[15] && hdr_re >= QPSK_TH) begin
              qpsk_d  = 1'b1;
              state_d = S_DATA;
            end else begin
              mode_err_d = 1'b1;
              state_d    = S_DROP;
            end
          end else begin
            car_d = car_q + CW'(1);
          end
        end else if (!bus.CYC_I) begin
          state_d = S_IDLE;
          car_d   = '0;
          sym_d   = '0;
        end
      end
      S_DATA: begin
        if (acc) begin
          if (pil_hit) begin
            pil_dat_d = bus.DAT_I;
            pil_idx_d = pil_k;
            pil_val_d = 1'b1;
          end else begin
            dat_o_d = bus.DAT_I;
            stb_o_d = 1'b1;
            cyc_o_d = 1'b1;
          end
          if (car_last) begin
            car_d = '0;
            sym_d = sym_q + 8'd1;
            if (sym_q == 8'(NSYM - 1)) begin
              frm_done_d = 1'b1;
              state_d    = S_DONE;
            end
          end else begin
            car_d = car_q + CW'(1);
          end
        end else if (!bus.CYC_I) begin
          // Abort: the output register keeps draining on its own.
          state_d = S_IDLE;
          car_d   = '0;
          sym_d   = '0;
          qam_d   = 1'b0;
          qpsk_d  = 1'b0;
        end
      end
      default: begin
        if (!bus.CYC_I) begin
          state_d = S_IDLE;
          car_d   = '0;
          sym_d   = '0;
          qam_d   = 1'b0;
          qpsk_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q    <= S_IDLE;
      car_q      <= '0;
      sym_q      <= '0;
      hdr_re_q   <= '0;
      qam_q      <= 1'b0;
      qpsk_q     <= 1'b0;
      dat_o_q    <= '0;
      stb_o_q    <= 1'b0;
      cyc_o_q    <= 1'b0;
      pil_dat_q  <= '0;
      pil_idx_q  <= '0;
      pil_val_q  <= 1'b0;
      mode_err_q <= 1'b0;
      frm_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      car_q      <= car_d;
      sym_q      <= sym_d;
      hdr_re_q   <= hdr_re_d;
      qam_q      <= qam_d;
      qpsk_q     <= qpsk_d;
      dat_o_q    <= dat_o_d;
      stb_o_q    <= stb_o_d;
      cyc_o_q    <= cyc_o_d;
      pil_dat_q  <= pil_dat_d;
      pil_idx_q  <= pil_idx_d;
      pil_val_q  <= pil_val_d;
      mode_err_q <= mode_err_d;
      frm_done_q <= frm_done_d;
    end
  end

  assign bus.ACK_O = acc;
  assign bus.DAT_O = dat_o_q;
  assign bus.STB_O = stb_o_q;
  assign bus.WE_O  = stb_o_q;
  assign bus.CYC_O = cyc_o_q;
  assign QAM       = qam_q;
  assign QPSK      = qpsk_q;
  assign PIL_DAT   = pil_dat_q;
  assign PIL_IDX   = pil_idx_q;
  assign PIL_VAL   = pil_val_q;
  assign SYM_CNT   = sym_q;
  assign MODE_ERR  = mode_err_q;
  assign FRM_DONE  = frm_done_q;
endmodule

// File: doc/demod_frame_sched.md
# demod_frame_sched

Frame scheduler that sits in front of the 16-QAM/QPSK data-symbol demodulator in the OFDM receive chain. It accepts equalised subcarrier samples over the Wishbone-style stream and sequences each frame. It strips the header symbol and decodes the frame's modulation from it, driving the demodulator's QAM/QPSK selects. It then forwards data carriers, diverts pilot carriers to a capture port, and counts symbols until the frame completes.

## Interface
Parameters:
- NCAR, 52: subcarrier samples per OFDM symbol (header and data).
- NSYM, 10: data symbols per frame after the header (1..255).
- HDR_IDX, 6: carrier index within the header symbol used for mode decode.
- PIL0/PIL1/PIL2/PIL3, 6/20/31/45: pilot carrier indices in data symbols (distinct, < NCAR).
- QAM_TH, 16'd1024: header real-part threshold for 16-QAM.
- QPSK_TH, 16'd128: header real-part threshold for QPSK.

Ports:
- CLK_I  in  1  system clock.
- RST_I  in  1  asynchronous active-low reset.
- DAT_I  in  32  sample; [31:16] Im, [15:0] Re, two's complement.
- CYC_I, STB_I, WE_I  in  1 each  upstream cycle/strobe/write.
- ACK_O  out  1  upstream acknowledge (combinational).
- DAT_O  out  32  forwarded data-carrier sample.
- CYC_O, STB_O, WE_O  out  1 each  downstream cycle/strobe/write; WE_O = STB_O.
- ACK_I  in  1  downstream acknowledge.
- QAM, QPSK  out  1 each  mode selects to demodulator; at most one high.
- PIL_DAT  out  32  captured pilot sample.
- PIL_IDX  out  2  which pilot (0..3).
- PIL_VAL  out  1  one-cycle pilot strobe.
- SYM_CNT  out  8  data symbols completed in current frame.
- MODE_ERR  out  1  one-cycle pulse, bad header.
- FRM_DONE  out  1  one-cycle pulse, frame complete.

## Operation
- ena = CYC_I & STB_I & WE_I; out_halt = STB_O & ~ACK_I; ACK_O = ena & ~out_halt in every state. A beat is "accepted" when ACK_O = 1.
- Carrier counter car (0..NCAR-1) advances on each accepted beat in HDR/DATA and wraps to 0 at NCAR-1. In DATA, each wrap increments SYM_CNT.
- States:
  - IDLE: counters 0. On ena, go to HDR; that beat is carrier 0 of the header.
  - HDR: no beat is forwarded. At car == HDR_IDX, latch Re.
    - At the accepted beat with car == NCAR-1, decode the latched Re: if Re[15]==0 and Re >= QAM_TH, set QAM=1 and go to DATA. Else if Re[15]==0 and Re >= QPSK_TH, set QPSK=1 and go to DATA. Else pulse MODE_ERR and go to DROP.
  - DATA: if car equals PILk, load the beat into PIL_DAT, set PIL_IDX=k and pulse PIL_VAL; the beat is not forwarded. Otherwise load it into the output register (DAT_O, STB_O=1). When the last carrier of symbol NSYM is accepted, pulse FRM_DONE and go to DONE.
  - DONE / DROP: accept and discard beats. When CYC_I=0, go to IDLE.
- CYC_I falling in HDR or DATA aborts the frame: go to IDLE, clear counters, SYM_CNT, QAM and QPSK. A beat already held in the output register is still delivered.
- QAM/QPSK stay stable from the decision until return to IDLE.
- CYC_O: set when a data beat is loaded. Cleared when CYC_I=0 and STB_O=0.
- Reset values: all outputs 0, state IDLE.

## Timing
- Output register is 1 deep. An accepted data beat appears on DAT_O/STB_O the next cycle.
- While out_halt=1, no beat is accepted, including pilots, and DAT_O/STB_O are held.
- When ACK_I=1, STB_O drops the next cycle unless a new data beat was accepted.
- PIL_VAL is asserted the cycle after its beat is accepted.
- QAM/QPSK assert the cycle after the last header beat is accepted, so they are valid before the first data beat reaches STB_O.
- FRM_DONE is asserted the cycle after the final beat is accepted, concurrent with that beat's STB_O if it is a data beat.
- Throughput: one beat per cycle when ACK_I is held high.
- Simultaneous CYC_I fall and final beat: the final beat wins. FRM_DONE pulses, then the block goes to IDLE.

## Test plan
- Header carrier 6 Re=16'd2000, 1 data symbol (NSYM=1), ACK_I=1 -> QAM=1, QPSK=0; 48 STB_O beats; PIL_VAL 4 times with PIL_IDX 0,1,2,3 carrying the beats at carriers 6/20/31/45; FRM_DONE once; SYM_CNT=1.
- Header Re=16'd500 -> QPSK=1. Header Re=16'hFF00 (negative) -> MODE_ERR pulse, no STB_O for the whole frame, IDLE after CYC_I falls.
- ACK_I low for 5 cycles mid-symbol -> ACK_O low during the stall, DAT_O held stable, no beat lost or duplicated; compare output against the reference sequence.
- CYC_I dropped at data carrier 10 of symbol 2 -> pending beat delivered, QAM/QPSK and SYM_CNT cleared, next frame decodes its own header correctly.
- RST_I pulsed low mid-DATA with STB_O=1 -> all outputs 0 immediately (asynchronous), state IDLE; the next full frame passes.
